// File: rtl/snake_head_ctrl.sv
// Snake head sequencer: draw, wait for frame tick, erase, wall check, step, redraw on a 160x120 grid.
// Define SNAKE_WRAP_EN to wrap the head across screen edges instead of ending the game at a wall.
module snake_head_ctrl #(
  parameter logic [7:0] X_START = 8'd80,
  parameter logic [6:0] Y_START = 7'd60,
  parameter logic [2:0] COLOUR  = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       tick,
  input  logic [1:0] dir_in,
  input  logic       dir_valid,
  input  logic       plot_ack,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot_req,
  output logic [1:0] dir,
  output logic       game_over
);

  localparam logic [7:0] X_MAX   = 8'd159;
  localparam logic [6:0] Y_MAX   = 7'd119;
  localparam logic [1:0] D_LEFT  = 2'd0;
  localparam logic [1:0] D_RIGHT = 2'd1;
  localparam logic [1:0] D_UP    = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_CHECK,
    S_STEP,
    S_DEAD
  } state_t;

  state_t     state_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_req_q;
  logic [1:0] dir_q;
  logic [1:0] pend_q;
  logic       game_over_q;

  logic [1:0] pend_d;
  logic       dir_live;
  logic       reversal;
  logic       wall_hit;
  logic       collide;
  logic [7:0] x_step;
  logic [6:0] y_step;
  logic [7:0] x_next;
  logic [6:0] y_next;

  // Requests are judged against the committed direction; a same-cycle request
  // on the commit edge still counts as "before commit".
  always_comb begin
    dir_live = (state_q == S_DRAW) || (state_q == S_WAIT) || (state_q == S_ERASE) ||
               (state_q == S_CHECK) || (state_q == S_STEP);
    reversal = (dir_in[1] == dir_q[1]) && (dir_in[0] != dir_q[0]);
    pend_d   = pend_q;
    if (dir_live && dir_valid && !reversal) begin
      pend_d = dir_in;
    end
  end

  always_comb begin
    wall_hit = 1'b0;
    x_step   = x_q;
    y_step   = y_q;
    case (dir_q)
      D_LEFT:  begin wall_hit = (x_q == 8'd0);  x_step = x_q - 8'd1; end
      D_RIGHT: begin wall_hit = (x_q == X_MAX); x_step = x_q + 8'd1; end
      D_UP:    begin wall_hit = (y_q == 7'd0);  y_step = y_q - 7'd1; end
      default: begin wall_hit = (y_q == Y_MAX); y_step = y_q + 7'd1; end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  always_comb begin
    x_next = x_step;
    y_next = y_step;
    if (wall_hit) begin
      case (dir_q)
        D_LEFT:  x_next = X_MAX;
        D_RIGHT: x_next = 8'd0;
        D_UP:    y_next = Y_MAX;
        default: y_next = 7'd0;
      endcase
    end
  end
  assign collide = 1'b0;
`else
  assign x_next  = x_step;
  assign y_next  = y_step;
  assign collide = wall_hit;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      x_q         <= X_START;
      y_q         <= Y_START;
      colour_q    <= 3'b000;
      plot_req_q  <= 1'b0;
      dir_q       <= D_RIGHT;
      pend_q      <= D_RIGHT;
      game_over_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_DRAW;
            plot_req_q <= 1'b1;
            colour_q   <= COLOUR;
          end
        end
        S_DRAW: begin
          if (plot_req_q && plot_ack) begin
            state_q    <= S_WAIT;
            plot_req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (tick) begin
            state_q    <= S_ERASE;
            plot_req_q <= 1'b1;
            colour_q   <= 3'b000;
          end
        end
        S_ERASE: begin
          if (plot_req_q && plot_ack) begin
            state_q    <= S_CHECK;
            plot_req_q <= 1'b0;
            dir_q      <= pend_d;
          end
        end
        S_CHECK: begin
          if (collide) begin
            state_q     <= S_DEAD;
            game_over_q <= 1'b1;
          end else begin
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          x_q        <= x_next;
          y_q        <= y_next;
          state_q    <= S_DRAW;
          plot_req_q <= 1'b1;
          colour_q   <= COLOUR;
        end
        S_DEAD: begin
          if (start) begin
            x_q         <= X_START;
            y_q         <= Y_START;
            dir_q       <= D_RIGHT;
            pend_q      <= D_RIGHT;
            game_over_q <= 1'b0;
            state_q     <= S_DRAW;
            plot_req_q  <= 1'b1;
            colour_q    <= COLOUR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot_req  = plot_req_q;
  assign dir       = dir_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl: a game-level head model feeds a plot scoreboard that a separate
// monitor drains on every accepted plot handshake; directed and random play sequences.
module tb_snake_head_ctrl;

  localparam logic [2:0] COLOUR = 3'b010;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       tick;
  logic [1:0] dir_in;
  logic       dir_valid;
  logic       plot_ack;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot_req;
  logic [1:0] dir;
  logic       game_over;

  snake_head_ctrl #(
    .X_START(8'd80),
    .Y_START(7'd60),
    .COLOUR (COLOUR)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .tick     (tick),
    .dir_in   (dir_in),
    .dir_valid(dir_valid),
    .plot_ack (plot_ack),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot_req (plot_req),
    .dir      (dir),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_mode = 0;  // 0: always ack, 1: random ack, 2: never ack

  int mx, my, mdir, mpend, mdead;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pix(input int px, input int py, input int pc);
    pix_t p;
    p.x = px;
    p.y = py;
    p.c = pc;
    sb.push_back(p);
  endtask

  function automatic bit is_reverse(input int a, input int b);
    return (a / 2 == b / 2) && (a != b);
  endfunction

  task automatic m_reset();
    mx = 80; my = 60; mdir = 1; mpend = 1; mdead = 0;
  endtask

  task automatic m_start();
    m_reset();
    push_pix(mx, my, int'(COLOUR));
  endtask

  task automatic m_request(input int d);
    if (!is_reverse(d, mdir)) mpend = d;
  endtask

  task automatic m_tick_begin();
    push_pix(mx, my, 0);
  endtask

  task automatic m_tick_end();
    int nx, ny;
    mdir = mpend;
    nx = mx;
    ny = my;
    case (mdir)
      0: nx = nx - 1;
      1: nx = nx + 1;
      2: ny = ny - 1;
      default: ny = ny + 1;
    endcase
    if (nx < 0 || nx > 159 || ny < 0 || ny > 119) begin
`ifdef SNAKE_WRAP_EN
      nx = (nx + 160) % 160;
      ny = (ny + 120) % 120;
`else
      mdead = 1;
      return;
`endif
    end
    mx = nx;
    my = ny;
    push_pix(mx, my, int'(COLOUR));
  endtask

  // Monitor: drives the ack and checks every accepted pixel against the scoreboard.
  logic hold_vld = 1'b0;
  int   hx, hy, hc;
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      case (ack_mode)
        0: plot_ack = 1'b1;
        1: plot_ack = ($urandom_range(0, 2) != 0);
        default: plot_ack = 1'b0;
      endcase
      if (resetn === 1'b1 && hold_vld) begin
        chk("hold_req", plot_req, 1);
        chk("hold_x", x, hx);
        chk("hold_y", y, hy);
        chk("hold_colour", colour, hc);
      end
      hold_vld = 1'b0;
      if (resetn === 1'b1 && plot_req === 1'b1) begin
        if (plot_ack) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%0d expected no plot", x, y, colour);
          end else begin
            e = sb.pop_front();
            chk("plot_x", x, e.x);
            chk("plot_y", y, e.y);
            chk("plot_colour", colour, e.c);
          end
        end else begin
          hold_vld = 1'b1;
          hx = x;
          hy = y;
          hc = colour;
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_rest();
    chk("head_x", x, mx);
    chk("head_y", y, my);
    chk("head_dir", dir, mdir);
    chk("game_over_low", game_over, 0);
  endtask

  task automatic wait_wait();
    int n = 0;
    while (!(sb.size() == 0 && plot_req === 1'b0)) begin
      cyc();
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL wait_timeout: got %0d pending plots expected 0", sb.size());
        return;
      end
    end
  endtask

  task automatic wait_dead();
    int n = 0;
    while (game_over !== 1'b1) begin
      cyc();
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL dead_timeout: got game_over=%0d expected 1", game_over);
        return;
      end
    end
    chk("dead_req", plot_req, 0);
    chk("dead_sb", sb.size(), 0);
  endtask

  task automatic req_dir(input int d);
    dir_in = d[1:0];
    dir_valid = 1'b1;
    m_request(d);
    cyc();
    dir_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    m_start();
    cyc();
    start = 1'b0;
    wait_wait();
    chk_rest();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    m_tick_begin();
    m_tick_end();
    cyc();
    tick = 1'b0;
    if (mdead != 0) wait_dead();
    else begin
      wait_wait();
      chk_rest();
    end
  endtask

  // Ack must be tied high here: checks exact cycle positions after the tick edge.
  task automatic timed_tick();
    int ox;
    ox = mx;
    tick = 1'b1;
    m_tick_begin();
    m_tick_end();
    @(posedge clk); #1; tick = 1'b0;
    @(posedge clk); #1;
    chk("t1_game_over", game_over, 0);
    chk("t1_req", plot_req, 0);
    @(posedge clk); #1;
    chk("t2_game_over", game_over, mdead);
    chk("t2_x", x, ox);
    @(posedge clk); #1;
    if (mdead != 0) begin
      chk("t3_dead_req", plot_req, 0);
      repeat (4) cyc();
      chk("dead_hold_req", plot_req, 0);
      chk("dead_hold_go", game_over, 1);
    end else begin
      chk("t3_x", x, mx);
      chk("t3_y", y, my);
      chk("t3_req", plot_req, 1);
      chk("t3_colour", colour, int'(COLOUR));
      wait_wait();
      chk_rest();
    end
  endtask

  initial begin
    int ox, oy;
    resetn = 1'b0; start = 1'b0; tick = 1'b0; dir_in = 2'd0; dir_valid = 1'b0;
    m_reset();
    repeat (3) cyc();
    chk("rst_req", plot_req, 0);
    chk("rst_x", x, 80);
    chk("rst_y", y, 60);
    chk("rst_dir", dir, 1);
    chk("rst_go", game_over, 0);
    chk("rst_colour", colour, 0);
    resetn = 1'b1;
    repeat (2) cyc();
    chk("idle_req", plot_req, 0);

    ack_mode = 0;
    do_start();
    timed_tick();

    req_dir(0);
    do_tick();
    chk("reverse_dir", dir, 1);

    // Stall the erase: requests 2 then 3 land before commit, stray tick is dropped.
    ack_mode = 2;
    tick = 1'b1;
    m_tick_begin();
    ox = mx;
    oy = my;
    cyc();
    tick = 1'b0;
    chk("stall_req", plot_req, 1);
    dir_in = 2'd2; dir_valid = 1'b1; m_request(2); cyc();
    dir_in = 2'd3; m_request(3); cyc();
    dir_valid = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc(); cyc();
    chk("stall_req_end", plot_req, 1);
    chk("stall_x", x, ox);
    chk("stall_y", y, oy);
    chk("stall_colour", colour, 0);
    m_tick_end();
    ack_mode = 0;
    wait_wait();
    chk_rest();
    repeat (8) cyc();
    chk("single_step_y", y, my);
    chk("single_step_req", plot_req, 0);

    // Run right into the wall, restart, then up into the top wall.
    ack_mode = 1;
    req_dir(1);
    while (mx < 159 && mdead == 0) do_tick();
    ack_mode = 0;
    timed_tick();
    if (mdead != 0) begin
      chk("dead_dir", dir, 1);
      do_start();
    end
    ack_mode = 1;
    req_dir(2);
    while (my > 0 && mdead == 0) do_tick();
    ack_mode = 0;
    timed_tick();
    if (mdead != 0) do_start();

    ack_mode = 1;
    for (int i = 0; i < 120; i++) begin
      if (mdead != 0) begin
        do_start();
      end else begin
        int nreq;
        nreq = $urandom_range(0, 2);
        for (int k = 0; k < nreq; k++) req_dir($urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) cyc();
        do_tick();
      end
    end

    // Reset while a DRAW is stalled at (81,60).
    resetn = 1'b0; sb.delete(); m_reset();
    cyc(); cyc();
    resetn = 1'b1;
    ack_mode = 0;
    do_start();
    tick = 1'b1;
    m_tick_begin();
    m_tick_end();
    @(posedge clk); #1; tick = 1'b0;
    @(posedge clk); #1; ack_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_req", plot_req, 1);
    chk("pre_rst_x", x, 81);
    resetn = 1'b0;
    sb.delete();
    m_reset();
    @(posedge clk); #1;
    chk("midrst_req", plot_req, 0);
    chk("midrst_x", x, 80);
    chk("midrst_y", y, 60);
    chk("midrst_dir", dir, 1);
    chk("midrst_go", game_over, 0);
    cyc();
    resetn = 1'b1;
    ack_mode = 0;
    repeat (4) cyc();
    chk("post_rst_idle_req", plot_req, 0);
    chk("post_rst_idle_x", x, 80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
